// File: rtl/icache_burst_plru.sv
// icache_burst_plru: set-associative I-cache with two-stage lookup, wrapping burst refill and tree PLRU.
// Also serves uncached single-beat fetches and CACHE maintenance ops through the same memory port.
module icache_burst_plru #(
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WORD_NUM = 8,
  parameter int ASSOC_NUM     = 2,
  parameter int SET_NUM       = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_req_valid,
  input  logic [31:0]           cpu_req_addr,
  input  logic                  cpu_req_cached,
  input  logic                  cpu_stall,
  input  logic                  cpu_flush,
  output logic                  cpu_busy,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cop_valid,
  input  logic [1:0]            cop_op,
  input  logic [31:0]           cop_addr,
  output logic                  cop_done,
  output logic                  mem_rd_req,
  output logic [31:0]           mem_rd_addr,
  output logic [7:0]            mem_rd_len,
  input  logic                  mem_rd_rdy,
  input  logic                  mem_ret_valid,
  input  logic                  mem_ret_last,
  input  logic [DATA_WIDTH-1:0] mem_ret_data
);
  localparam int WO = $clog2(LINE_WORD_NUM);
  localparam int OW = WO + 2;
  localparam int IW = $clog2(SET_NUM);
  localparam int TW = 32 - IW - OW;
  localparam int LA = $clog2(ASSOC_NUM);
  localparam int WW = LA > 0 ? LA : 1;
  localparam int PW = ASSOC_NUM > 1 ? ASSOC_NUM - 1 : 1;
  typedef enum logic [3:0] {
    INIT, LOOKUP, MISS_REQ, REFILL, REFILL_DONE, UNC_REQ, UNC_WAIT, UNC_DONE, COP_RD, COP_WR, INV_ALL
  } state_t;
  state_t state;
  logic [TW-1:0]         tag_ram   [ASSOC_NUM][SET_NUM];
  logic [ASSOC_NUM-1:0]  valid_ram [SET_NUM];
  logic [DATA_WIDTH-1:0] data_ram  [ASSOC_NUM][SET_NUM][LINE_WORD_NUM];
  logic [PW:1]           plru      [SET_NUM];
  logic [TW-1:0]         rd_tag    [ASSOC_NUM];
  logic [DATA_WIDTH-1:0] rd_data   [ASSOC_NUM];
  logic [ASSOC_NUM-1:0]  rd_valid;
  logic [DATA_WIDTH-1:0] lbuf      [LINE_WORD_NUM];
  logic [DATA_WIDTH-1:0] unc_data, hit_word;
  logic [IW-1:0]         cnt, rd_idx;
  logic [WO-1:0]         beat, rd_off;
  logic [WW-1:0]         victim, vic_n, hit_way;
  logic [ASSOC_NUM-1:0]  hit_vec, cop_match;
  logic [31:0]           s2_addr;
  logic                  s2_valid, s2_cached, s2_hit, s2_miss, s2_unc, capture, cop_go, fill, look, done_st;
  logic                  unused_bits;
  wire [TW-1:0] s2_tag  = s2_addr[31:32-TW];
  wire [IW-1:0] s2_idx  = s2_addr[OW+IW-1:OW];
  wire [WO-1:0] s2_off  = s2_addr[OW-1:2];
  wire [TW-1:0] cop_tag = cop_addr[31:32-TW];
  wire [IW-1:0] cop_idx = cop_addr[OW+IW-1:OW];
  assign unused_bits = ^{cpu_req_addr[1:0], cop_addr[OW-1:0]};
  // Heap-ordered tree: node n has children 2n/2n+1, a bit of 1 steers the victim right.
  function automatic logic [WW-1:0] plru_victim(input logic [PW:1] p);
    int n = 1;
    for (int l = 0; l < LA; l++) n = 2 * n + int'(p[n]);
    return WW'(n - ASSOC_NUM);
  endfunction
  function automatic logic [PW:1] plru_touch(input logic [PW:1] p, input logic [WW-1:0] w);
    int n = 1;
    for (int l = LA - 1; l >= 0; l--) begin
      p[n] = ~w[l];
      n = 2 * n + int'(w[l]);
    end
    return p;
  endfunction
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    hit_word = '0;
    cop_match = '0;
    vic_n = plru_victim(plru[s2_idx]);
    for (int i = 0; i < ASSOC_NUM; i++) begin
      cop_match[i] = rd_valid[i] && rd_tag[i] == cop_tag;
      if (rd_valid[i] && rd_tag[i] == s2_tag) begin
        hit_vec[i] = 1'b1;
        hit_way = WW'(i);
        hit_word = rd_data[i];
      end
    end
    for (int i = ASSOC_NUM - 1; i >= 0; i--) if (!rd_valid[i]) vic_n = WW'(i);
  end
  assign look     = state == LOOKUP;
  assign done_st  = state == REFILL_DONE || state == UNC_DONE;
  assign s2_hit   = s2_valid && s2_cached && |hit_vec;
  assign s2_miss  = s2_valid && s2_cached && !(|hit_vec);
  assign s2_unc   = s2_valid && !s2_cached;
  assign cpu_busy = look ? (s2_miss || s2_unc || cop_valid) : !done_st;
  assign capture  = !cpu_busy && !cpu_stall;
  assign cop_go   = look && cop_valid && !s2_miss && !s2_unc && !(s2_hit && cpu_stall);
  assign fill     = state == REFILL && mem_ret_valid && mem_ret_last;
  assign cpu_rvalid = look ? s2_hit : done_st && s2_valid;
  assign cpu_rdata  = !cpu_rvalid ? '0 : look ? hit_word : state == REFILL_DONE ? lbuf[s2_off] : unc_data;
  assign cop_done   = state == COP_WR || (state == INV_ALL && cnt == IW'(SET_NUM - 1));
  assign mem_rd_req  = state == MISS_REQ || state == UNC_REQ;
  assign mem_rd_addr = mem_rd_req ? s2_addr : '0;
  assign mem_rd_len  = state == MISS_REQ ? 8'(LINE_WORD_NUM - 1) : 8'd0;
  // A stalled hit keeps re-reading its own index so the delivered word stays stable.
  assign rd_idx = state == COP_RD ? cop_idx : capture ? cpu_req_addr[OW+IW-1:OW] : s2_idx;
  assign rd_off = capture ? cpu_req_addr[OW-1:2] : s2_off;
  always_ff @(posedge clk) begin
    for (int i = 0; i < ASSOC_NUM; i++) begin
      rd_tag[i] <= tag_ram[i][rd_idx];
      rd_data[i] <= data_ram[i][rd_idx][rd_off];
    end
    rd_valid <= valid_ram[rd_idx];
    if (state == INIT || state == INV_ALL) valid_ram[cnt] <= '0;
    if (state == COP_WR)
      valid_ram[cop_idx] <= cop_op == 2'b00 ? '0 : cop_op == 2'b01 ? valid_ram[cop_idx] & ~cop_match : valid_ram[cop_idx];
    if (fill) begin
      tag_ram[victim][s2_idx] <= s2_tag;
      valid_ram[s2_idx][victim] <= 1'b1;
      for (int w = 0; w < LINE_WORD_NUM; w++)
        data_ram[victim][s2_idx][w] <= WO'(w) == beat ? mem_ret_data : lbuf[w];
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= INIT;
      cnt <= '0;
      s2_valid <= 1'b0;
      s2_addr <= '0;
      s2_cached <= 1'b0;
      victim <= '0;
      beat <= '0;
      unc_data <= '0;
      for (int w = 0; w < LINE_WORD_NUM; w++) lbuf[w] <= '0;
      for (int s = 0; s < SET_NUM; s++) plru[s] <= '0;
    end else begin
      if (capture) begin
        s2_valid <= cpu_req_valid;
        s2_addr <= cpu_req_addr;
        s2_cached <= cpu_req_cached;
      end else if (cpu_flush || cop_go) s2_valid <= 1'b0;
      if (s2_hit && look) plru[s2_idx] <= plru_touch(plru[s2_idx], hit_way);
      if (fill) plru[s2_idx] <= plru_touch(plru[s2_idx], victim);
      case (state)
        INIT, INV_ALL: begin
          cnt <= cnt + 1'b1;
          if (cnt == IW'(SET_NUM - 1)) state <= LOOKUP;
        end
        LOOKUP:
          if (!cpu_flush && s2_miss) state <= MISS_REQ;
          else if (!cpu_flush && s2_unc) state <= UNC_REQ;
          else if (cop_go) state <= cop_op == 2'b10 ? INV_ALL : COP_RD;
        MISS_REQ: begin
          victim <= vic_n;
          beat <= s2_off;
          if (mem_rd_rdy) state <= REFILL;
          else if (cpu_flush) state <= LOOKUP;
        end
        REFILL:
          if (mem_ret_valid) begin
            lbuf[beat] <= mem_ret_data;
            beat <= beat + 1'b1;
            if (mem_ret_last) state <= s2_valid && !cpu_flush ? REFILL_DONE : LOOKUP;
          end
        UNC_REQ:
          if (mem_rd_rdy) state <= UNC_WAIT;
          else if (cpu_flush) state <= LOOKUP;
        UNC_WAIT:
          if (mem_ret_valid) begin
            unc_data <= mem_ret_data;
            state <= s2_valid && !cpu_flush ? UNC_DONE : LOOKUP;
          end
        REFILL_DONE, UNC_DONE: if (!cpu_stall || cpu_flush) state <= LOOKUP;
        COP_RD: state <= COP_WR;
        default: state <= LOOKUP;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_burst_plru.sv
// tb_icache_burst_plru: directed self-checking bench for icache_burst_plru (default parameters).
module tb_icache_burst_plru;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        cpu_req_valid = 1'b0, cpu_req_cached = 1'b0, cpu_stall = 1'b0, cpu_flush = 1'b0;
  logic [31:0] cpu_req_addr = '0, cop_addr = '0, mem_ret_data = '0;
  logic        cop_valid = 1'b0, mem_rd_rdy = 1'b0, mem_ret_valid = 1'b0, mem_ret_last = 1'b0;
  logic [1:0]  cop_op = 2'b00;
  logic        cpu_busy, cpu_rvalid, cop_done, mem_rd_req;
  logic [31:0] cpu_rdata, mem_rd_addr;
  logic [7:0]  mem_rd_len;
  int checks = 0, passed = 0;
  icache_burst_plru dut (
    .clk(clk), .resetn(resetn), .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
    .cpu_req_cached(cpu_req_cached), .cpu_stall(cpu_stall), .cpu_flush(cpu_flush), .cpu_busy(cpu_busy),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cop_valid(cop_valid), .cop_op(cop_op),
    .cop_addr(cop_addr), .cop_done(cop_done), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_len(mem_rd_len), .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid),
    .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  // Backing memory contents: word address xor a fixed pattern.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A5A5A;
  endfunction
  task automatic issue(input logic [31:0] a, input logic c);
    cpu_req_valid = 1'b1;
    cpu_req_addr = a;
    cpu_req_cached = c;
    @(negedge clk);
    cpu_req_valid = 1'b0;
  endtask
  task automatic serve_refill(input string nm, input logic [31:0] a, input int flush_beat);
    int n = 0;
    logic [2:0] w;
    while (!mem_rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== a || mem_rd_len !== 8'd7)
      $display("FAIL %s_req got req=%b addr=%h len=%0d want req=1 addr=%h len=7", nm, mem_rd_req, mem_rd_addr, mem_rd_len, a);
    else passed++;
    mem_rd_rdy = 1'b1;
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w = a[4:2] + 3'(k);
      mem_ret_valid = 1'b1;
      mem_ret_last = k == 7;
      mem_ret_data = mw({a[31:5], w, 2'b00});
      cpu_flush = k == flush_beat;
      @(negedge clk);
    end
    mem_ret_valid = 1'b0;
    mem_ret_last = 1'b0;
    cpu_flush = 1'b0;
  endtask
  task automatic miss_fetch(input string nm, input logic [31:0] a, input logic [31:0] exp);
    issue(a, 1'b1);
    checks++;
    if (cpu_busy !== 1'b1 || cpu_rvalid !== 1'b0)
      $display("FAIL %s_miss got busy=%b rvalid=%b want busy=1 rvalid=0", nm, cpu_busy, cpu_rvalid);
    else passed++;
    serve_refill(nm, a, -1);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp)
      $display("FAIL %s_data got rvalid=%b rdata=%h want rvalid=1 rdata=%h", nm, cpu_rvalid, cpu_rdata, exp);
    else passed++;
    @(negedge clk);
  endtask
  task automatic hit_fetch(input string nm, input logic [31:0] a, input logic [31:0] exp);
    issue(a, 1'b1);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_busy !== 1'b0 || cpu_rdata !== exp)
      $display("FAIL %s_hit got rvalid=%b busy=%b rdata=%h want rvalid=1 busy=0 rdata=%h", nm, cpu_rvalid, cpu_busy, cpu_rdata, exp);
    else passed++;
  endtask
  task automatic run_cop(input string nm, input logic [1:0] op, input logic [31:0] a, input int exp_cyc);
    int n = 0;
    cop_valid = 1'b1;
    cop_op = op;
    cop_addr = a;
    do begin
      @(negedge clk);
      n++;
    end while (!cop_done && n < 300);
    checks++;
    if (cop_done !== 1'b1 || n != exp_cyc)
      $display("FAIL %s_done got done=%b cycles=%0d want done=1 cycles=%0d", nm, cop_done, n, exp_cyc);
    else passed++;
    cop_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    int n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_busy !== 1'b1 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || cop_done !== 1'b0)
      $display("FAIL reset_cpu got busy=%b rvalid=%b rdata=%h done=%b want 1 0 0 0", cpu_busy, cpu_rvalid, cpu_rdata, cop_done);
    else passed++;
    checks++;
    if (mem_rd_req !== 1'b0 || mem_rd_addr !== 32'h0 || mem_rd_len !== 8'd0)
      $display("FAIL reset_mem got req=%b addr=%h len=%0d want 0 0 0", mem_rd_req, mem_rd_addr, mem_rd_len);
    else passed++;
    resetn = 1'b1;
    while (cpu_busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 128) $display("FAIL init_busy got %0d cycles want 128", n);
    else passed++;
    miss_fetch("post_init", 32'h0, 32'h5A5A5A5A);
  endtask
  task automatic test_wrap_refill();
    miss_fetch("wrap", 32'h1FC00014, 32'h459A5A4E);
    hit_fetch("wrap_w0", 32'h1FC00000, 32'h459A5A5A);
    hit_fetch("wrap_w7", 32'h1FC0001C, 32'h459A5A46);
  endtask
  task automatic test_plru();
    hit_fetch("plru_0", 32'h0, 32'h5A5A5A5A);
    miss_fetch("plru_1000", 32'h1000, 32'h5A5A4A5A);
    miss_fetch("plru_2000", 32'h2000, 32'h5A5A7A5A);
    hit_fetch("plru_keep", 32'h1000, 32'h5A5A4A5A);
    miss_fetch("plru_evicted", 32'h0, 32'h5A5A5A5A);
  endtask
  task automatic test_uncached();
    for (int r = 0; r < 2; r++) begin
      int n = 0;
      issue(32'hBFC00000, 1'b0);
      while (!mem_rd_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'hBFC00000 || mem_rd_len !== 8'd0)
        $display("FAIL unc_req%0d got req=%b addr=%h len=%0d want 1 bfc00000 0", r, mem_rd_req, mem_rd_addr, mem_rd_len);
      else passed++;
      mem_rd_rdy = 1'b1;
      @(negedge clk);
      mem_rd_rdy = 1'b0;
      mem_ret_valid = 1'b1;
      mem_ret_last = 1'b1;
      mem_ret_data = 32'h3C08BFC0;
      @(negedge clk);
      mem_ret_valid = 1'b0;
      mem_ret_last = 1'b0;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h3C08BFC0)
        $display("FAIL unc_data%0d got rvalid=%b rdata=%h want 1 3c08bfc0", r, cpu_rvalid, cpu_rdata);
      else passed++;
      @(negedge clk);
      checks++;
      if (cpu_rvalid !== 1'b0) $display("FAIL unc_once%0d got rvalid=%b want 0", r, cpu_rvalid);
      else passed++;
    end
  endtask
  task automatic test_flush_refill();
    issue(32'h4040, 1'b1);
    serve_refill("flush", 32'h4040, 2);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_busy !== 1'b0)
      $display("FAIL flush_norv got rvalid=%b busy=%b want 0 0", cpu_rvalid, cpu_busy);
    else passed++;
    @(negedge clk);
    hit_fetch("flush_refetch", 32'h4040, 32'h5A5A1A1A);
  endtask
  task automatic test_cop();
    run_cop("hitinv", 2'b01, 32'h1000, 2);
    hit_fetch("hitinv_other", 32'h0, 32'h5A5A5A5A);
    miss_fetch("hitinv_gone", 32'h1000, 32'h5A5A4A5A);
    run_cop("invall", 2'b10, 32'h0, 128);
    miss_fetch("invall_0", 32'h0, 32'h5A5A5A5A);
    miss_fetch("invall_4040", 32'h4040, 32'h5A5A1A1A);
    run_cop("idxinv", 2'b00, 32'h7040, 2);
    miss_fetch("idxinv_gone", 32'h4040, 32'h5A5A1A1A);
    hit_fetch("idxinv_other", 32'h0, 32'h5A5A5A5A);
  endtask
  task automatic test_back_to_back();
    cpu_req_valid = 1'b1;
    cpu_req_addr = 32'h4040;
    cpu_req_cached = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5A5A1A1A)
      $display("FAIL b2b_first got rvalid=%b rdata=%h want 1 5a5a1a1a", cpu_rvalid, cpu_rdata);
    else passed++;
    cpu_stall = 1'b1;
    cpu_req_addr = 32'h0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_busy !== 1'b0 || cpu_rdata !== 32'h5A5A1A1A)
      $display("FAIL stall_hold got rvalid=%b busy=%b rdata=%h want 1 0 5a5a1a1a", cpu_rvalid, cpu_busy, cpu_rdata);
    else passed++;
    cpu_stall = 1'b0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5A5A5A5A)
      $display("FAIL b2b_second got rvalid=%b rdata=%h want 1 5a5a5a5a", cpu_rvalid, cpu_rdata);
    else passed++;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_wrap_refill();
    test_plru();
    test_uncached();
    test_flush_refill();
    test_cop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
